// File: rtl/life_pkg.sv
// Shared types and constants for the life generation controller.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam int BOARD_W = 256;

    // Board register reset/seed pattern: top 16 cells alive.
    localparam logic [BOARD_W-1:0] RESET_PATTERN = {{16{1'b1}}, {(BOARD_W-16){1'b0}}};

endpackage

// File: rtl/life_gen_ctrl_if.sv
// Control and board-register signals between the user side and the sequencer.
interface life_gen_ctrl_if #(
    parameter int WIDTH = 256,
    parameter int DIV_W = 24,
    parameter int GEN_W = 16
);
    logic             start;
    logic             stop;
    logic             step;
    logic             seed;
    logic [DIV_W-1:0] period;
    logic [WIDTH-1:0] board_q;
    logic [WIDTH-1:0] board_d;
    logic             reg_en;
    logic             reg_clear;
    logic [GEN_W-1:0] gen_count;
    logic [1:0]       state_o;
    logic             stable;
    logic             extinct;

    // Driver of the controls and the board values.
    modport master (
        output start, stop, step, seed, period, board_q, board_d,
        input  reg_en, reg_clear, gen_count, state_o, stable, extinct
    );

    // The sequencer itself.
    modport slave (
        input  start, stop, step, seed, period, board_q, board_d,
        output reg_en, reg_clear, gen_count, state_o, stable, extinct
    );
endinterface

// File: rtl/life_gen_ctrl_gen_tick_div.sv
// Generation period divider: counts while enabled, fires a terminal pulse
// when the count reaches max(period,1)-1, then wraps to zero.
module gen_tick_div #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] last;

    // Period 0 behaves like period 1 (fire every cycle).
    assign last = (period == '0) ? '0 : period - 1'b1;

    // Next count and terminal pulse; >= lets a shrunk period wrap at once.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q >= last) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/life_gen_ctrl.sv
// Sequencer for the board-state register: seed, single-step and free-run,
// halting on a still or empty board, with a saturating generation count.
module life_gen_ctrl
    import life_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int DIV_W = 24,
    parameter int GEN_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    life_gen_ctrl_if.slave  bus
);
    state_e           state_q, state_d;
    logic             reg_en_q, reg_en_d;
    logic             reg_clear_q, reg_clear_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             stable_q, stable_d;
    logic [WIDTH-1:0] bq, bd;
    logic             tick, adv_edge, same_board, extinct;

    assign bq         = bus.board_q;
    assign bd         = bus.board_d;
    assign same_board = (bd == bq);
    assign extinct    = (bq == '0);
    // Pulse currently at the register that advances rather than seeds.
    assign adv_edge   = reg_en_q & ~reg_clear_q;

    gen_tick_div #(.DIV_W(DIV_W)) u_div (
        .clk    (clk),
        .reset  (reset),
        .en     (state_q == RUN),
        .period (bus.period),
        .tick   (tick)
    );

    // Next state, pulse decisions and generation bookkeeping. A new pulse is
    // only issued when none is in flight, so reg_en never lasts two cycles;
    // a seed/step arriving while a pulse is in flight is dropped.
    always_comb begin
        state_d     = state_q;
        reg_en_d    = 1'b0;
        reg_clear_d = 1'b0;
        gen_d       = gen_q;
        stable_d    = stable_q;

        // An advance already issued completes even if stop arrives now.
        if (adv_edge) begin
            if (gen_q != {GEN_W{1'b1}}) gen_d = gen_q + 1'b1;
            stable_d = same_board;
        end

        case (state_q)
            IDLE: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (bus.seed) begin
                    if (!reg_en_q) begin
                        reg_en_d    = 1'b1;
                        reg_clear_d = 1'b1;
                        gen_d       = '0;
                        stable_d    = 1'b0;
                    end
                end else if (bus.start) begin
                    state_d = RUN;
                end else if (bus.step && !reg_en_q) begin
                    reg_en_d = 1'b1;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (adv_edge && same_board) begin
                    state_d = HALT;
                end else if (extinct && !reg_en_q) begin
                    state_d = HALT;
                end else if (tick && !reg_en_q) begin
                    reg_en_d = 1'b1;
                end
            end
            HALT: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (bus.seed && !reg_en_q) begin
                    state_d     = IDLE;
                    reg_en_d    = 1'b1;
                    reg_clear_d = 1'b1;
                    gen_d       = '0;
                    stable_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any pending pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            reg_en_q    <= 1'b0;
            reg_clear_q <= 1'b0;
            gen_q       <= '0;
            stable_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            reg_en_q    <= reg_en_d;
            reg_clear_q <= reg_clear_d;
            gen_q       <= gen_d;
            stable_q    <= stable_d;
        end
    end

    assign bus.reg_en    = reg_en_q;
    assign bus.reg_clear = reg_clear_q;
    assign bus.gen_count = gen_q;
    assign bus.state_o   = state_q;
    assign bus.stable    = stable_q;
    assign bus.extinct   = extinct;
endmodule

// File: tb/tb_life_gen_ctrl.sv
// Bench for life_gen_ctrl: vector table for single-cycle decisions, a pulse
// scoreboard keyed by cycle number, and sequences for run/halt corner cases.
module tb_life_gen_ctrl;
    import life_pkg::*;

    localparam int W  = BOARD_W;
    localparam int DW = 24;
    localparam int GW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    life_gen_ctrl_if #(.WIDTH(W), .DIV_W(DW), .GEN_W(GW)) b();
    life_gen_ctrl_if #(.WIDTH(W), .DIV_W(DW), .GEN_W(4))  s();

    life_gen_ctrl #(.WIDTH(W), .DIV_W(DW), .GEN_W(GW)) dut (
        .clk(clk), .reset(reset), .bus(b)
    );
    // Narrow generation counter so saturation is reachable quickly.
    life_gen_ctrl #(.WIDTH(W), .DIV_W(DW), .GEN_W(4)) dut_sat (
        .clk(clk), .reset(reset), .bus(s)
    );

    typedef struct {
        int   cyc;
        logic clr;
    } exp_t;

    typedef struct {
        logic        st, sp, stp, sd;
        logic [1:0]  st_o;
        logic        en, clr;
        logic [15:0] gen;
    } tv_t;

    exp_t sb_q[$];
    tv_t  tv[9];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_n   = 0;
    int   k;
    logic prev_en = 1'b0;

    logic [W-1:0] blink_a, blink_b, block;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    task automatic expect_pulse(input int at, input logic clr);
        exp_t e;
        e.cyc = at;
        e.clr = clr;
        sb_q.push_back(e);
    endtask

    // One clock; outputs sampled on the falling edge and pulses scored.
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        cyc_n++;
        @(negedge clk);
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc_n) begin
            e = sb_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL sb_missed: no reg_en seen, expected at cycle %0d", e.cyc);
        end
        if (b.reg_en) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: reg_en=1 clr=%0b at cycle %0d, expected none", b.reg_clear, cyc_n);
            end else begin
                e = sb_q.pop_front();
                if (e.cyc != cyc_n || e.clr !== b.reg_clear) begin
                    n_fail++;
                    $display("FAIL sb_pulse: got cycle %0d clr %0b, expected cycle %0d clr %0b",
                             cyc_n, b.reg_clear, e.cyc, e.clr);
                end
            end
        end
        if (b.reg_en && prev_en) begin
            n_fail++;
            $display("FAIL back_to_back: reg_en high two cycles at %0d, expected single pulse", cyc_n);
        end
        if (b.reg_clear && !b.reg_en) begin
            n_fail++;
            $display("FAIL clr_alone: reg_clear=1 reg_en=0 at %0d, expected clear only with en", cyc_n);
        end
        prev_en = b.reg_en;
    endtask

    task automatic set_in(input logic st, input logic sp, input logic stp, input logic sd);
        b.start = st;
        b.stop  = sp;
        b.step  = stp;
        b.seed  = sd;
    endtask

    initial begin
        blink_a = '0;
        blink_b = '0;
        block   = '0;
        blink_a[2:0]   = 3'b111;
        blink_b[1]     = 1'b1;
        blink_b[17]    = 1'b1;
        blink_b[33]    = 1'b1;
        block[1:0]     = 2'b11;
        block[17:16]   = 2'b11;

        //        st sp stp sd  state en clr gen
        tv[0] = '{0, 0, 0, 1, 2'd0, 1, 1, 16'd0}; // seed
        tv[1] = '{0, 0, 0, 0, 2'd0, 0, 0, 16'd0};
        tv[2] = '{0, 0, 1, 0, 2'd0, 1, 0, 16'd0}; // step
        tv[3] = '{0, 0, 0, 0, 2'd0, 0, 0, 16'd1}; // step counted
        tv[4] = '{1, 1, 1, 1, 2'd0, 0, 0, 16'd1}; // stop wins
        tv[5] = '{1, 0, 1, 1, 2'd0, 1, 1, 16'd0}; // seed over start/step
        tv[6] = '{0, 0, 0, 0, 2'd0, 0, 0, 16'd0};
        tv[7] = '{1, 0, 1, 0, 2'd1, 0, 0, 16'd0}; // start over step
        tv[8] = '{0, 1, 0, 0, 2'd0, 0, 0, 16'd0}; // stop leaves RUN

        reset     = 1'b1;
        set_in(0, 0, 0, 0);
        b.period  = 24'd100;
        b.board_q = RESET_PATTERN;
        b.board_d = blink_a;
        s.start = 1'b0; s.stop = 1'b0; s.step = 1'b0; s.seed = 1'b0;
        s.period  = 24'd1;
        s.board_q = blink_a;
        s.board_d = blink_b;

        // Reset state.
        repeat (2) cyc();
        chk("rst_state", b.state_o, 2'd0);
        chk("rst_en", b.reg_en, 1'b0);
        chk("rst_clr", b.reg_clear, 1'b0);
        chk("rst_gen", b.gen_count, 16'd0);
        chk("rst_stable", b.stable, 1'b0);
        chk("extinct_nz", b.extinct, 1'b0);
        reset = 1'b0;
        cyc();

        // Single-cycle decision table from IDLE.
        for (int i = 0; i < 9; i++) begin
            set_in(tv[i].st, tv[i].sp, tv[i].stp, tv[i].sd);
            if (tv[i].en) expect_pulse(cyc_n + 1, tv[i].clr);
            cyc();
            chk($sformatf("tbl%0d_state", i), b.state_o, tv[i].st_o);
            chk($sformatf("tbl%0d_gen", i), b.gen_count, tv[i].gen);
        end
        set_in(0, 0, 0, 0);
        cyc();

        // Three spaced single steps.
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 1, 0);
            expect_pulse(cyc_n + 1, 1'b0);
            cyc();
            set_in(0, 0, 0, 0);
            repeat (3) cyc();
        end
        chk("step3_gen", b.gen_count, 16'd3);
        chk("step3_state", b.state_o, 2'd0);

        // Free run, period 5, then shrink to 2; stop with a pulse in flight.
        b.board_q = blink_a;
        b.board_d = blink_b;
        b.period  = 24'd5;
        set_in(1, 0, 0, 0);
        cyc();
        k = cyc_n;
        chk("run_state", b.state_o, 2'd1);
        set_in(0, 0, 0, 0);
        expect_pulse(k + 5, 1'b0);
        expect_pulse(k + 10, 1'b0);
        expect_pulse(k + 13, 1'b0);
        expect_pulse(k + 15, 1'b0);
        expect_pulse(k + 17, 1'b0);
        while (cyc_n < k + 12) cyc();
        b.period = 24'd2;
        while (cyc_n < k + 17) cyc();
        set_in(0, 1, 0, 0);
        cyc();
        set_in(0, 0, 0, 0);
        chk("run_stop_state", b.state_o, 2'd0);
        chk("run_gen_inflight", b.gen_count, 16'd8);
        chk("run_stable", b.stable, 1'b0);
        cyc();

        // Still life: first advance is stable, then HALT with no more pulses.
        b.board_q = block;
        b.board_d = block;
        b.period  = 24'd1;
        set_in(1, 0, 0, 0);
        expect_pulse(cyc_n + 2, 1'b0);
        cyc();
        set_in(0, 0, 0, 0);
        cyc();
        cyc();
        chk("still_state", b.state_o, 2'd2);
        chk("still_stable", b.stable, 1'b1);
        chk("still_gen", b.gen_count, 16'd9);
        set_in(1, 0, 1, 0);
        repeat (5) cyc();
        chk("still_hold", b.state_o, 2'd2);
        set_in(0, 0, 0, 1);
        expect_pulse(cyc_n + 1, 1'b1);
        cyc();
        set_in(0, 0, 0, 0);
        chk("halt_seed_state", b.state_o, 2'd0);
        chk("halt_seed_gen", b.gen_count, 16'd0);
        chk("halt_seed_stable", b.stable, 1'b0);
        cyc();

        // Empty board: RUN drops straight to HALT without an advance.
        b.board_q = '0;
        b.board_d = '0;
        #1;
        chk("extinct_z", b.extinct, 1'b1);
        set_in(1, 0, 0, 0);
        cyc();
        chk("ext_run", b.state_o, 2'd1);
        set_in(0, 0, 0, 0);
        cyc();
        chk("ext_halt", b.state_o, 2'd2);
        set_in(1, 0, 1, 0);
        cyc();
        chk("ext_ignore", b.state_o, 2'd2);
        set_in(0, 1, 0, 0);
        cyc();
        chk("ext_stop", b.state_o, 2'd0);
        set_in(0, 0, 0, 0);
        cyc();

        // Stop just before a tick cancels the advance.
        b.board_q = blink_a;
        b.board_d = blink_b;
        b.period  = 24'd3;
        set_in(1, 0, 0, 0);
        cyc();
        set_in(0, 0, 0, 0);
        cyc();
        cyc();
        set_in(0, 1, 0, 0);
        cyc();
        set_in(0, 0, 0, 0);
        chk("cancel_state", b.state_o, 2'd0);
        cyc();
        chk("cancel_gen", b.gen_count, 16'd0);

        // Reset mid-run with a pulse in flight clears everything.
        set_in(1, 0, 0, 0);
        cyc();
        k = cyc_n;
        set_in(0, 0, 0, 0);
        expect_pulse(k + 3, 1'b0);
        expect_pulse(k + 6, 1'b0);
        while (cyc_n < k + 6) cyc();
        chk("mid_gen", b.gen_count, 16'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("mid_rst_state", b.state_o, 2'd0);
        chk("mid_rst_en", b.reg_en, 1'b0);
        chk("mid_rst_gen", b.gen_count, 16'd0);
        chk("mid_rst_stable", b.stable, 1'b0);
        repeat (4) cyc();
        chk("mid_rst_idle", b.state_o, 2'd0);

        // Saturation on the narrow counter.
        s.start = 1'b1;
        cyc();
        s.start = 1'b0;
        repeat (40) cyc();
        chk("sat_gen", s.gen_count, 4'hF);
        chk("sat_state", s.state_o, 2'd1);

        repeat (3) cyc();
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_left: %0d pulses outstanding, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
